// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the writeback sources, the arbiter and the register file.
// The master side drives requests and ClearReq and sees the register-file write port.
// The slave side (the arbiter) owns the grants and the write port.
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 24,
  parameter int ADDR_W  = 4
);
  logic                       clear_req;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*ADDR_W-1:0]  req_rd;
  logic [NUM_REQ*DATA_W-1:0]  req_data;
  logic [NUM_REQ-1:0]         req_ready;
  logic [ADDR_W-1:0]          rd;
  logic [DATA_W-1:0]          write_data;
  logic                       regwrite;
  logic                       busy;

  modport master (
    output clear_req, req_valid, req_rd, req_data,
    input  req_ready, rd, write_data, regwrite, busy
  );

  modport slave (
    input  clear_req, req_valid, req_rd, req_data,
    output req_ready, rd, write_data, regwrite, busy
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Owns the register file's single write port. Sweeps every register to zero after
// reset or on a clear request (the register file has no reset), then shares the port
// among NUM_REQ writeback sources with round-robin arbitration, one write per cycle.
module regfile_write_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int DATA_W   = 24,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  regfile_write_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    last, gidx;
  logic [NUM_REQ-1:0]  grant;
  logic                xfer, sweep_done;

  assign sweep_done    = (cnt == CNT_W'(NUM_REGS - 1));
  assign bus.req_ready = grant;
  assign bus.busy      = (state == CLEAR);

  // Round-robin pick: first valid requester after the last winner, wrapping around.
  // A clear request suppresses all grants so nothing is accepted that cycle.
  always_comb begin
    xfer = 1'b0;
    gidx = last;
    if (state == RUN && !bus.clear_req) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (!xfer && bus.req_valid[(int'(last) + k) % NUM_REQ]) begin
          xfer = 1'b1;
          gidx = IDX_W'((int'(last) + k) % NUM_REQ);
        end
      end
    end
    grant = xfer ? (NUM_REQ'(1) << gidx) : '0;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CLEAR;
    else        state <= state_nxt;
  end

  // Next state: leave CLEAR on the edge that issues the final register; a clear
  // request in RUN restarts the sweep. Clear requests during a sweep are ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (sweep_done)    state_nxt = RUN;
      RUN:     if (bus.clear_req) state_nxt = CLEAR;
      default: state_nxt = CLEAR;
    endcase
  end

  // Registered write port, sweep counter and last-winner pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      last           <= IDX_W'(NUM_REQ - 1);
      bus.regwrite   <= 1'b0;
      bus.rd         <= '0;
      bus.write_data <= '0;
    end else begin
      case (state)
        CLEAR: begin
          bus.regwrite   <= 1'b1;
          bus.rd         <= ADDR_W'(cnt);
          bus.write_data <= '0;
          cnt            <= sweep_done ? '0 : cnt + 1'b1;
        end
        default: begin
          // cnt is parked at 0 so a clear from RUN always starts at register 0.
          cnt <= '0;
          if (xfer) begin
            bus.regwrite   <= 1'b1;
            bus.rd         <= bus.req_rd[int'(gidx)*ADDR_W +: ADDR_W];
            bus.write_data <= bus.req_data[int'(gidx)*DATA_W +: DATA_W];
            last           <= gidx;
          end else begin
            bus.regwrite   <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios followed by random traffic, all
// checked against a transaction-level model (pending requests, round-robin pointer,
// sweep progress, expected register contents) plus a simple register-file memory.
module tb_regfile_write_arbiter;
  localparam int NR   = 3;
  localparam int DW   = 24;
  localparam int AW   = 4;
  localparam int NREG = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) bus();

  regfile_write_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NREG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Register file: no reset, commits one edge after the arbiter's registered outputs.
  logic [DW-1:0] mem [NREG];
  always @(posedge clk) if (bus.regwrite) mem[bus.rd] <= bus.write_data;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit             m_busy;
  int             m_cnt;
  int             m_last;
  logic           exp_we;
  logic [AW-1:0]  exp_rd;
  logic [DW-1:0]  exp_wd;
  logic [DW-1:0]  m_regs [NREG];
  // Requester side: a request stays pending until granted
  bit             p_vld  [NR];
  logic [AW-1:0]  p_rd   [NR];
  logic [DW-1:0]  p_data [NR];

  function automatic int rr_pick();
    for (int k = 1; k <= NR; k++) begin
      if (p_vld[(m_last + k) % NR]) return (m_last + k) % NR;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b1;
    m_cnt  = 0;
    m_last = NR - 1;
    exp_we = 1'b0;
    exp_rd = '0;
    exp_wd = '0;
  endtask

  // One cycle, entered and left at a falling edge.
  task automatic step(input bit clr);
    int g;
    logic [NR-1:0] exp_rdy;
    chk("regwrite", 32'(bus.regwrite), 32'(exp_we));
    chk("rd", 32'(bus.rd), 32'(exp_rd));
    chk("write_data", 32'(bus.write_data), 32'(exp_wd));
    chk("busy", 32'(bus.busy), 32'(m_busy));
    bus.clear_req = clr;
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]            = p_vld[i];
      bus.req_rd[i*AW +: AW]      = p_rd[i];
      bus.req_data[i*DW +: DW]    = p_data[i];
    end
    #1;
    exp_rdy = '0;
    if (m_busy) begin
      exp_we = 1'b1;
      exp_rd = AW'(m_cnt);
      exp_wd = '0;
      m_regs[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == NREG) m_busy = 1'b0;
    end else if (clr) begin
      exp_we = 1'b0;
      m_busy = 1'b1;
      m_cnt  = 0;
    end else begin
      g = rr_pick();
      if (g >= 0) begin
        exp_rdy[g] = 1'b1;
        exp_we = 1'b1;
        exp_rd = p_rd[g];
        exp_wd = p_data[g];
        m_regs[p_rd[g]] = p_data[g];
        m_last = g;
        p_vld[g] = 1'b0;
      end else begin
        exp_we = 1'b0;
      end
    end
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] r, input logic [DW-1:0] d);
    p_vld[i]  = 1'b1;
    p_rd[i]   = r;
    p_data[i] = d;
  endtask

  task automatic check_regs();
    for (int i = 0; i < NREG; i++) chk($sformatf("reg%0d", i), 32'(mem[i]), 32'(m_regs[i]));
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin
      mem[i]    = DW'($urandom);
      m_regs[i] = 'x;
    end
    for (int i = 0; i < NR; i++) begin
      p_vld[i] = 1'b0; p_rd[i] = '0; p_data[i] = '0;
    end
    bus.clear_req = 1'b0;
    bus.req_valid = '1;
    bus.req_rd    = '0;
    bus.req_data  = '0;
    model_reset();

    // Reset state: no grants even with requests valid, busy high, write port idle.
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_regwrite", 32'(bus.regwrite), 32'd0);
    chk("rst_rd", 32'(bus.rd), 32'd0);
    chk("rst_wdata", 32'(bus.write_data), 32'd0);
    bus.req_valid = '0;
    rst_n = 1'b1;

    // Sweep after reset release, then idle.
    repeat (NREG + 2) step(1'b0);

    // All three requesters at once: granted 0,1,2 in turn.
    set_req(0, 4'd1, 24'h00000A);
    set_req(1, 4'd2, 24'h00000B);
    set_req(2, 4'd3, 24'h00000C);
    repeat (4) step(1'b0);

    // Single requester keeps getting granted, no bubbles.
    for (int j = 0; j < 4; j++) begin
      set_req(2, 4'd5, (j < 2) ? 24'hFFFFFF : 24'h123456);
      step(1'b0);
    end

    // Make req1 the last winner, then a same-register collision between req0 and req1.
    set_req(1, 4'd0, 24'h000001);
    step(1'b0);
    set_req(0, 4'd7, 24'h111111);
    set_req(1, 4'd7, 24'h222222);
    repeat (4) step(1'b0);
    chk("reg1_const", 32'(mem[1]), 32'h00000A);
    chk("reg2_const", 32'(mem[2]), 32'h00000B);
    chk("reg3_const", 32'(mem[3]), 32'h00000C);
    chk("reg5_const", 32'(mem[5]), 32'h123456);
    chk("reg7_const", 32'(mem[7]), 32'h222222);

    // Clear with a pending request: held through the sweep, then granted.
    set_req(1, 4'd9, 24'h5A5A5A);
    step(1'b1);
    repeat (NREG + 3) step(1'b0);
    chk("reg9_const", 32'(mem[9]), 32'h5A5A5A);
    chk("reg7_cleared", 32'(mem[7]), 32'h0);
    check_regs();

    // Reset mid-sweep at cnt 9: outputs return to reset values at once, sweep restarts.
    step(1'b1);
    repeat (9) step(1'b0);
    chk("mid_rd_before", 32'(bus.rd), 32'd8);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_regwrite", 32'(bus.regwrite), 32'd0);
    chk("mid_rst_rd", 32'(bus.rd), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd1);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (NREG + 2) step(1'b0);

    // Random traffic with occasional clear requests (some land mid-sweep).
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!p_vld[i] && ($urandom_range(1, 0) == 1))
          set_req(i, AW'($urandom_range(NREG - 1, 0)), DW'($urandom));
      end
      step($urandom_range(39, 0) == 0);
    end
    repeat (NREG + NR + 4) step(1'b0);
    check_regs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
